// File: rtl/hex_spin_scheduler.sv
// Sequencer for the HEX4..HEX2 digits: prescaled 8-step perimeter spinner
// with a one-shot message client that pre-empts it for HOLD_TICKS steps.
module hex_spin_scheduler #(
    parameter int unsigned TICK_DIV   = 6_250_000,
    parameter int unsigned HOLD_TICKS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        msg_valid,
    input  logic [20:0] msg_pattern,
    output logic        msg_ready,
    output logic        msg_done,
    output logic [2:0]  step,
    output logic        busy,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(1'b0);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1'b1);
    localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1'b1);
    localparam logic [HW-1:0] HOLD_ZERO  = HW'(1'b0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SPIN = 2'd1;
    localparam logic [1:0] ST_MSG  = 2'd2;

    localparam logic [6:0]  SEG_OFF = 7'h7F;
    localparam logic [6:0]  SEG_TOP = 7'h7E;
    localparam logic [6:0]  SEG_UR  = 7'h7D;
    localparam logic [6:0]  SEG_LR  = 7'h7B;
    localparam logic [6:0]  SEG_BOT = 7'h77;
    localparam logic [20:0] ALL_OFF = {SEG_OFF, SEG_OFF, SEG_OFF};

    // Perimeter walk: across the top left to right, down the right side, back along the bottom.
    function automatic logic [20:0] spin_map(input logic [2:0] s);
        logic [20:0] r;
        case (s)
            3'd0:    r = {SEG_TOP, SEG_OFF, SEG_OFF};
            3'd1:    r = {SEG_OFF, SEG_TOP, SEG_OFF};
            3'd2:    r = {SEG_OFF, SEG_OFF, SEG_TOP};
            3'd3:    r = {SEG_OFF, SEG_OFF, SEG_UR};
            3'd4:    r = {SEG_OFF, SEG_OFF, SEG_LR};
            3'd5:    r = {SEG_OFF, SEG_OFF, SEG_BOT};
            3'd6:    r = {SEG_OFF, SEG_BOT, SEG_OFF};
            3'd7:    r = {SEG_BOT, SEG_OFF, SEG_OFF};
            default: r = ALL_OFF;
        endcase
        return r;
    endfunction

    logic [PW-1:0] presc_q;
    logic [1:0]    state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [20:0]   pat_q, pat_d;
    logic [20:0]   hex_q, hex_d;
    logic          done_q, done_d;
    logic          ready_q, busy_q;
    logic          tick_s, accept_s;

    assign tick_s   = (presc_q == PRESC_MAX);
    assign accept_s = msg_valid & ready_q;

    // Free-running step prescaler; deliberately untouched by state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= PRESC_ZERO;
        end else if (tick_s) begin
            presc_q <= PRESC_ZERO;
        end else begin
            presc_q <= presc_q + PRESC_ONE;
        end
    end

    // Next-state logic: accept beats an enable change, which beats a tick.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        hold_d  = hold_q;
        pat_d   = pat_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                step_d = 3'd0;
                if (accept_s) begin
                    state_d = ST_MSG;
                    hold_d  = HOLD_INIT;
                    pat_d   = msg_pattern;
                end else if (enable) begin
                    state_d = ST_SPIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SPIN: begin
                if (accept_s) begin
                    state_d = ST_MSG;
                    hold_d  = HOLD_INIT;
                    pat_d   = msg_pattern;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                    step_d  = 3'd0;
                end else if (tick_s) begin
                    step_d = step_q + 3'd1;
                end else begin
                    step_d = step_q;
                end
            end
            ST_MSG: begin
                if (tick_s && (hold_q == HOLD_ONE)) begin
                    hold_d  = HOLD_ZERO;
                    done_d  = 1'b1;
                    state_d = enable ? ST_SPIN : ST_IDLE;
                    step_d  = enable ? step_q : 3'd0;
                end else if (tick_s) begin
                    hold_d = hold_q - HOLD_ONE;
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = 3'd0;
                hold_d  = HOLD_ZERO;
            end
        endcase
    end

    // Display source follows the registered state, giving one cycle of latency.
    always_comb begin
        case (state_q)
            ST_MSG:  hex_d = pat_q;
            ST_SPIN: hex_d = spin_map(step_q);
            default: hex_d = ALL_OFF;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= 3'd0;
            hold_q  <= HOLD_ZERO;
            pat_q   <= ALL_OFF;
            hex_q   <= ALL_OFF;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            pat_q   <= pat_d;
            hex_q   <= hex_d;
            done_q  <= done_d;
            ready_q <= (state_d != ST_MSG);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign HEX4      = hex_q[20:14];
    assign HEX3      = hex_q[13:7];
    assign HEX2      = hex_q[6:0];
    assign msg_ready = ready_q;
    assign msg_done  = done_q;
    assign step      = step_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_hex_spin_scheduler.sv
// Scenario bench for hex_spin_scheduler with TICK_DIV=4, HOLD_TICKS=3.
module tb_hex_spin_scheduler;

    localparam int TD = 4;
    localparam int HT = 3;
    localparam logic [20:0] OFF3  = 21'h1F_FFFF;
    localparam logic [20:0] PAT_A = 21'h0C_3086;
    localparam logic [20:0] PAT_B = 21'h15_5555;
    localparam logic [20:0] PAT_C = 21'h0A_AAAA;
    localparam logic [20:0] PAT_D = 21'h1E_0F0F;

    logic        clk = 1'b0;
    logic        rst, enable, msg_valid;
    logic [20:0] msg_pattern;
    logic        msg_ready, msg_done, busy;
    logic [2:0]  step;
    logic [6:0]  HEX4, HEX3, HEX2;

    int total = 0;
    int bad   = 0;
    int tb_cnt = 0;

    hex_spin_scheduler #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .msg_valid(msg_valid),
        .msg_pattern(msg_pattern), .msg_ready(msg_ready), .msg_done(msg_done),
        .step(step), .busy(busy), .HEX4(HEX4), .HEX3(HEX3), .HEX2(HEX2)
    );

    always #5 clk = ~clk;

    // Independent view of the prescaler phase: tick is the cycle where tb_cnt == TD-1.
    always @(posedge clk) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == TD - 1) ? 0 : tb_cnt + 1;
    end

    function automatic logic [20:0] spin_map(input logic [2:0] s);
        case (s)
            3'd0:    return {7'h7E, 7'h7F, 7'h7F};
            3'd1:    return {7'h7F, 7'h7E, 7'h7F};
            3'd2:    return {7'h7F, 7'h7F, 7'h7E};
            3'd3:    return {7'h7F, 7'h7F, 7'h7D};
            3'd4:    return {7'h7F, 7'h7F, 7'h7B};
            3'd5:    return {7'h7F, 7'h7F, 7'h77};
            3'd6:    return {7'h7F, 7'h77, 7'h7F};
            default: return {7'h77, 7'h7F, 7'h7F};
        endcase
    endfunction

    task automatic wait_tick_cycle();
        @(negedge clk);
        while (tb_cnt != TD - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; msg_valid = 1'b0; msg_pattern = 21'h00_0000;
        repeat (3) @(negedge clk);
        total++;
        if ({HEX4, HEX3, HEX2} !== OFF3) begin
            bad++; $display("FAIL reset_hex: got %h expected %h", {HEX4, HEX3, HEX2}, OFF3);
        end
        total++;
        if ({msg_ready, msg_done, busy, step} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            bad++; $display("FAIL reset_ctrl: got rdy/done/busy/step %b%b%b/%0d expected 100/0",
                            msg_ready, msg_done, busy, step);
        end
        rst = 1'b0;
    endtask

    task automatic test_spin();
        logic [2:0] q[$];
        logic [2:0] exp_s, prev_s;
        enable = 1'b1;
        prev_s = 3'd0;
        q.push_back(3'd0);
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            exp_s = q.pop_front();
            total++;
            if (step !== exp_s || busy !== 1'b1) begin
                bad++; $display("FAIL spin_step: cycle %0d got step=%0d busy=%b expected step=%0d busy=1",
                                i, step, busy, exp_s);
            end
            if (i > 0) begin
                total++;
                if ({HEX4, HEX3, HEX2} !== spin_map(prev_s)) begin
                    bad++; $display("FAIL spin_hex: cycle %0d got %h expected %h",
                                    i, {HEX4, HEX3, HEX2}, spin_map(prev_s));
                end
            end
            prev_s = exp_s;
            q.push_back((tb_cnt == TD - 1) ? exp_s + 3'd1 : exp_s);
        end
    endtask

    task automatic test_msg_preempt();
        int n;
        int done_q[$];
        logic exp_done;
        n = 0;
        @(negedge clk);
        while (!(step == 3'd5 && tb_cnt == TD - 1) && n < 100) begin
            @(negedge clk); n++;
        end
        total++;
        if (n >= 100) begin
            bad++; $display("FAIL preempt_align: got step=%0d expected step 5 on a tick", step);
        end
        msg_valid = 1'b1; msg_pattern = PAT_A;
        done_q.push_back(1 + HT * TD);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 1) msg_valid = 1'b0;
            exp_done = (done_q.size() > 0 && done_q[0] == i);
            if (exp_done) void'(done_q.pop_front());
            total++;
            if ({msg_ready, msg_done, step} !== {(i >= 13), exp_done, 3'd5}) begin
                bad++; $display("FAIL preempt_ctrl: idx %0d got rdy/done/step %b%b/%0d expected %b%b/5",
                                i, msg_ready, msg_done, step, (i >= 13), exp_done);
            end
            if (i >= 2 && i <= 13) begin
                total++;
                if ({HEX4, HEX3, HEX2} !== PAT_A) begin
                    bad++; $display("FAIL preempt_hex: idx %0d got %h expected %h", i, {HEX4, HEX3, HEX2}, PAT_A);
                end
            end
            if (i == 14) begin
                total++;
                if ({HEX4, HEX3, HEX2} !== spin_map(3'd5)) begin
                    bad++; $display("FAIL preempt_resume: got %h expected %h", {HEX4, HEX3, HEX2}, spin_map(3'd5));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int done_q[$];
        logic exp_done, exp_rdy;
        wait_tick_cycle();
        msg_valid = 1'b1; msg_pattern = PAT_B;
        done_q.push_back(13);
        done_q.push_back(25);
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            if (i == 1) msg_pattern = PAT_C;
            if (i == 14) msg_valid = 1'b0;
            exp_done = (done_q.size() > 0 && done_q[0] == i);
            if (exp_done) void'(done_q.pop_front());
            exp_rdy = !((i <= 12) || (i >= 14 && i <= 24));
            total++;
            if (msg_done !== exp_done || msg_ready !== exp_rdy) begin
                bad++; $display("FAIL b2b_ctrl: idx %0d got done/rdy %b%b expected %b%b",
                                i, msg_done, msg_ready, exp_done, exp_rdy);
            end
            if ((i >= 2 && i <= 13) || (i >= 15 && i <= 25)) begin
                total++;
                if ({HEX4, HEX3, HEX2} !== ((i <= 13) ? PAT_B : PAT_C)) begin
                    bad++; $display("FAIL b2b_hex: idx %0d got %h expected %h",
                                    i, {HEX4, HEX3, HEX2}, (i <= 13) ? PAT_B : PAT_C);
                end
            end
        end
    endtask

    task automatic test_drop_enable();
        int n;
        n = 0;
        @(negedge clk);
        while (step != 3'd3 && n < 100) begin
            @(negedge clk); n++;
        end
        total++;
        if (n >= 100) begin
            bad++; $display("FAIL drop_align: got step=%0d expected 3", step);
        end
        enable = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, step, msg_ready} !== {1'b0, 3'd0, 1'b1}) begin
            bad++; $display("FAIL drop_state: got busy/step/rdy %b/%0d/%b expected 0/0/1", busy, step, msg_ready);
        end
        total++;
        if ({HEX4, HEX3, HEX2} !== spin_map(3'd3)) begin
            bad++; $display("FAIL drop_latency: got %h expected %h", {HEX4, HEX3, HEX2}, spin_map(3'd3));
        end
        @(negedge clk);
        total++;
        if ({HEX4, HEX3, HEX2} !== OFF3) begin
            bad++; $display("FAIL drop_blank: got %h expected %h", {HEX4, HEX3, HEX2}, OFF3);
        end
    endtask

    task automatic test_idle_msg();
        logic [20:0] exp_hex;
        wait_tick_cycle();
        total++;
        if ({HEX4, HEX3, HEX2} !== OFF3 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_pre: got hex=%h busy=%b expected %h busy=0", {HEX4, HEX3, HEX2}, busy, OFF3);
        end
        msg_valid = 1'b1; msg_pattern = PAT_D;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) msg_valid = 1'b0;
            exp_hex = (i >= 2 && i <= 13) ? PAT_D : OFF3;
            total++;
            if ({msg_done, busy, step} !== {(i == 13), (i < 13), 3'd0}) begin
                bad++; $display("FAIL idle_ctrl: idx %0d got done/busy/step %b%b/%0d expected %b%b/0",
                                i, msg_done, busy, step, (i == 13), (i < 13));
            end
            total++;
            if ({HEX4, HEX3, HEX2} !== exp_hex) begin
                bad++; $display("FAIL idle_hex: idx %0d got %h expected %h", i, {HEX4, HEX3, HEX2}, exp_hex);
            end
        end
    endtask

    task automatic test_reset_mid_msg();
        wait_tick_cycle();
        enable = 1'b1; msg_valid = 1'b1; msg_pattern = PAT_A;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 1) msg_valid = 1'b0;
            if (i <= 9) begin
                total++;
                if ({msg_ready, busy} !== 2'b01) begin
                    bad++; $display("FAIL rmsg_inmsg: idx %0d got rdy/busy %b%b expected 01", i, msg_ready, busy);
                end
            end else if (i <= 11) begin
                total++;
                if ({msg_ready, msg_done, busy, step, HEX4, HEX3, HEX2} !== {1'b1, 1'b0, 1'b0, 3'd0, OFF3}) begin
                    bad++; $display("FAIL rmsg_reset: idx %0d got rdy/done/busy/step %b%b%b/%0d hex=%h expected 100/0 %h",
                                    i, msg_ready, msg_done, busy, step, {HEX4, HEX3, HEX2}, OFF3);
                end
            end else begin
                total++;
                if ({msg_done, busy, step} !== {1'b0, 1'b1, (i >= 15) ? 3'd1 : 3'd0}) begin
                    bad++; $display("FAIL rmsg_restart: idx %0d got done/busy/step %b%b/%0d expected 01/%0d",
                                    i, msg_done, busy, step, (i >= 15) ? 1 : 0);
                end
            end
            if (i == 9) rst = 1'b1;
            if (i == 11) rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_spin();
        test_msg_preempt();
        test_back_to_back();
        test_drop_enable();
        test_idle_msg();
        test_reset_mid_msg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/hex_spin_scheduler.md
# hex_spin_scheduler

Controller that owns the three left seven-segment digits (HEX4, HEX3, HEX2) and sequences what they show. It generates its own animation step timing from a clock prescaler and runs the 8-step perimeter "spinner". It also arbitrates a one-shot message client that can pre-empt the spinner for a fixed number of steps. It replaces driving the spinner from raw counter bits and sits between the game/top-level logic and the HEX pins.

## Interface
- TICK_DIV, 6_250_000, clk cycles per animation step (8 steps/s at 50 MHz); legal range ≥ 2.
- HOLD_TICKS, 16, number of step ticks a message stays on the digits; legal range ≥ 1.
- clk  in  1  system clock; everything is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = spinner runs, 0 = digits blank when no message is showing.
- msg_valid  in  1  message request; held until accepted.
- msg_pattern  in  21  {HEX4, HEX3, HEX2} segment codes; sampled on accept.
- msg_ready  out  1  high whenever state ≠ MSG.
- msg_done  out  1  one-cycle pulse when a message finishes.
- step  out  3  current spinner step.
- busy  out  1  high when state ≠ IDLE.
- HEX4, HEX3, HEX2  out  7 each  active-low segments; bit0 = a (top) … bit6 = g.

## Operation
- Segment codes from the shared params header: off 7'h7F, top 7'h7E, upper_right 7'h7D, lower_right 7'h7B, bottom 7'h77.
- Prescaler:
  - Free-running from reset; counts 0..TICK_DIV-1 and wraps.
  - tick is high for the single cycle where the count = TICK_DIV-1.
  - The prescaler is never cleared by a state change.
- Spinner map, step → {HEX4, HEX3, HEX2}, with every unlisted digit = off:
  - 0: HEX4 = top
  - 1: HEX3 = top
  - 2: HEX2 = top
  - 3: HEX2 = upper_right
  - 4: HEX2 = lower_right
  - 5: HEX2 = bottom
  - 6: HEX3 = bottom
  - 7: HEX4 = bottom
- FSM states are IDLE, SPIN and MSG.
- IDLE:
  - step forced to 0; digits all off.
  - If accept, go to MSG.
  - Else if enable, go to SPIN.
- SPIN:
  - On tick, step increments and wraps 7 → 0.
  - If accept, go to MSG; step is not advanced that cycle, even if tick is also high.
  - Else if !enable, go to IDLE.
- MSG:
  - Digits show the latched pattern; step is frozen.
  - The hold counter is loaded with HOLD_TICKS on accept and decrements on each tick.
  - On the tick where the counter = 1, exit: go to SPIN (step unchanged) if enable, else IDLE.
- accept = msg_valid & msg_ready.
- Priority in IDLE/SPIN: accept > enable change > tick.
- msg_valid during MSG is ignored (msg_ready is 0); no queueing.

## Timing
- Reset values:
  - state IDLE, step 0, prescaler 0, hold counter 0.
  - HEX4 = HEX3 = HEX2 = 7'h7F.
  - msg_ready 1, msg_done 0, busy 0.
- HEX outputs are registered from state, step and the latched pattern: one cycle of latency after any state or step register change.
- Accept at cycle N:
  - state = MSG and msg_ready = 0 at N+1.
  - Pattern appears on HEX at N+2.
- Message display spans exactly HOLD_TICKS ticks. The first tick counted is the first tick strictly after the accept cycle; a tick in the accept cycle does not count.
- msg_done is high on the cycle after the exiting tick, which is the same cycle the new state is visible. msg_ready returns to 1 on that cycle too.
- enable edges take effect on the next cycle. When step reaches 0 on leaving SPIN for IDLE, the display is blank one cycle later.
- rst asserted mid-message aborts it: reset values are applied on the next edge and msg_done is not pulsed.

## Test plan
Bench uses TICK_DIV = 4, HOLD_TICKS = 3.
- Reset, then enable = 1 held for 36 cycles:
  - step sequence 0,1,…,7,0 advancing every 4 cycles.
  - At step 3, HEX2 = 7'h7D with HEX4 = HEX3 = 7'h7F.
  - At step 7, HEX4 = 7'h77.
- In SPIN at step 5, msg_valid with pattern 21'h0C_3086 in the same cycle as tick:
  - Accepted; step stays 5; msg_ready is 0 the next cycle; HEX shows the pattern 2 cycles after accept.
  - After 3 ticks, msg_done pulses once and the spinner resumes at step 5.
- msg_valid held high through the whole message: the second request is accepted on the cycle msg_done pulses (msg_ready = 1), and the display shows the new pattern for another 3 ticks.
- enable = 0, then a message:
  - Digits are 7'h7F before and after the message; busy falls with msg_done.
  - Drop enable mid-spin: step returns to 0 and the display goes blank the next cycle.
- rst asserted 2 ticks into a message:
  - All outputs return to reset values; no msg_done.
  - IDLE with step 0 after deassert; the spinner restarts from step 0 if enable = 1.
